// File: rtl/hazard_pkg.sv
// Shared encodings and the pipeline-slot record for the forwarding/hazard controller.
package hazard_pkg;

    localparam int REG_BITS = 5;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_MEM     = 2'd1;
    localparam logic [1:0] FWD_WB      = 2'd2;

    localparam logic [1:0] REGDST_RT   = 2'd0;
    localparam logic [1:0] REGDST_RD   = 2'd1;
    localparam logic [1:0] REGDST_RA   = 2'd2;
    localparam logic [1:0] REGDST_NONE = 2'd3;

    localparam logic [REG_BITS-1:0] REG_RA   = 5'd31;
    localparam logic [REG_BITS-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] dest;
        logic                regwrite;
        logic                memread;
    } pipe_slot_t;

    // A slot produces a usable value for reg r; $0 is hardwired and never produced.
    function automatic logic slot_writes(input pipe_slot_t s, input logic [REG_BITS-1:0] r);
        return s.valid && s.regwrite && (s.dest != REG_ZERO) && (s.dest == r);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX source: youngest producer (MEM) wins over WB.
module fwd_select
    import hazard_pkg::*;
(
    input  pipe_slot_t          mem_slot,
    input  pipe_slot_t          wb_slot,
    input  logic [REG_BITS-1:0] src,
    input  logic                enable,
    output logic [1:0]          sel
);

    logic unused_memread;
    assign unused_memread = mem_slot.memread ^ wb_slot.memread;

    always_comb begin
        sel = FWD_REGFILE;
        if (enable) begin
            if (slot_writes(mem_slot, src)) begin
                sel = FWD_MEM;
            end else if (slot_writes(wb_slot, src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Tracks in-flight destinations through EX/MEM/WB and drives operand forwarding
// selects plus the one-cycle load-use stall for the five-stage pipeline.
module fwd_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ID_Valid,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic [REG_W-1:0] ID_Rd,
    input  logic             ID_UsesRt,
    input  logic [1:0]       ID_RegDst,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             Flush,
    output logic [REG_W-1:0] ID_WriteReg,
    output logic             Stall,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] StallCount
);

    pipe_slot_t       ex_q, ex_d;
    pipe_slot_t       mem_q, mem_d;
    pipe_slot_t       wb_q, wb_d;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;
    logic             ex_uses_rt_q, ex_uses_rt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        unique case (ID_RegDst)
            REGDST_RT: ID_WriteReg = ID_Rt;
            REGDST_RD: ID_WriteReg = ID_Rd;
            REGDST_RA: ID_WriteReg = REG_RA;
            default:   ID_WriteReg = REG_ZERO;
        endcase
    end

    // Flush wins over the load-use condition: the consumer is being killed anyway.
    always_comb begin
        Stall = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.dest != REG_ZERO)
             && ID_Valid && !Flush
             && ((ex_q.dest == ID_Rs) || (ID_UsesRt && (ex_q.dest == ID_Rt)));
    end

    always_comb begin
        ex_d.valid    = ID_Valid && !Flush && !Stall;
        ex_d.dest     = ID_WriteReg;
        ex_d.regwrite = ID_RegWrite;
        ex_d.memread  = ID_MemRead;
        ex_rs_d       = ID_Rs;
        ex_rt_d       = ID_Rt;
        ex_uses_rt_d  = ID_UsesRt;
        mem_d         = ex_q;
        wb_d          = mem_q;
        stall_cnt_d   = Stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    // Slot payloads are don't-care while invalid, so only valid bits and the counter reset.
    always_ff @(posedge Clk) begin
        ex_q         <= ex_d;
        mem_q        <= mem_d;
        wb_q         <= wb_d;
        ex_rs_q      <= ex_rs_d;
        ex_rt_q      <= ex_rt_d;
        ex_uses_rt_q <= ex_uses_rt_d;
        stall_cnt_q  <= stall_cnt_d;
        if (Reset) begin
            ex_q.valid  <= 1'b0;
            mem_q.valid <= 1'b0;
            wb_q.valid  <= 1'b0;
            stall_cnt_q <= '0;
        end
    end

    fwd_select u_fwd_a (
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .src      (ex_rs_q),
        .enable   (1'b1),
        .sel      (ForwardA)
    );

    fwd_select u_fwd_b (
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .src      (ex_rt_q),
        .enable   (ex_uses_rt_q),
        .sel      (ForwardB)
    );

    assign StallCount = stall_cnt_q;

endmodule
